// File: rtl/fft_frame_feeder.sv
// Ping-pong frame buffer that turns a valid/ready sample stream into
// back-to-back FFT_SIZE-cycle in_valid bursts for the FFT core.
module fft_frame_feeder #(
  parameter int FFT_SIZE   = 32,
  parameter int IN_WIDTH   = 12,
  parameter int GAP_CYCLES = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [IN_WIDTH-1:0] s_data_r,
  input  logic [IN_WIDTH-1:0] s_data_i,
  input  logic                fft_idle,
  output logic                in_valid,
  output logic [IN_WIDTH-1:0] din_r,
  output logic [IN_WIDTH-1:0] din_i,
  output logic                frame_sent,
  output logic [7:0]          frames_sent
);

  localparam int AW = $clog2(FFT_SIZE);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int DW = 2 * IN_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP} state_t;

  state_t                state_q, state_d;
  logic [1:0]            full_q, full_d;
  logic                  w_bank_q, w_bank_d;
  logic                  r_bank_q, r_bank_d;
  logic [AW-1:0]         w_idx_q, w_idx_d;
  logic [AW-1:0]         rd_idx_q, rd_idx_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [7:0]            frames_q, frames_d;
  logic                  in_valid_q, in_valid_d;
  logic [IN_WIDTH-1:0]   din_r_q, din_r_d;
  logic [IN_WIDTH-1:0]   din_i_q, din_i_d;
  logic                  frame_sent_q, frame_sent_d;

  logic [DW-1:0]         bank_mem [2][FFT_SIZE];
  logic                  wr_en;
  logic [AW-1:0]         rd_addr;
  logic [DW-1:0]         rd_word;

  assign s_ready = !full_q[w_bank_q];
  assign wr_en   = s_valid && s_ready;

  // Read index is zero whenever the FSM is idle; forcing it here keeps
  // sample 0 correct even if that invariant were ever broken.
  assign rd_addr = (state_q == S_IDLE) ? '0 : rd_idx_q;
  assign rd_word = bank_mem[r_bank_q][rd_addr];

  always_ff @(posedge clk) begin
    if (wr_en) bank_mem[w_bank_q][w_idx_q] <= {s_data_r, s_data_i};
  end

  always_comb begin
    state_d      = state_q;
    full_d       = full_q;
    w_bank_d     = w_bank_q;
    r_bank_d     = r_bank_q;
    w_idx_d      = w_idx_q;
    rd_idx_d     = rd_idx_q;
    gap_d        = gap_q;
    frames_d     = frames_q;
    in_valid_d   = 1'b0;
    din_r_d      = '0;
    din_i_d      = '0;
    frame_sent_d = 1'b0;

    if (wr_en) begin
      w_idx_d = w_idx_q + AW'(1);
      if (w_idx_q == AW'(FFT_SIZE - 1)) begin
        full_d[w_bank_q] = 1'b1;
        w_bank_d         = ~w_bank_q;
      end
    end

    // Write and read never touch the same bank's flag in one cycle:
    // writes need an empty bank, sends need a full one.
    case (state_q)
      S_IDLE: begin
        if (full_q[r_bank_q] && fft_idle) begin
          state_d    = S_BURST;
          rd_idx_d   = AW'(1);
          in_valid_d = 1'b1;
          din_r_d    = rd_word[DW-1:IN_WIDTH];
          din_i_d    = rd_word[IN_WIDTH-1:0];
        end
      end
      S_BURST: begin
        // rd_idx wraps to 0 once the last sample is on the outputs.
        if (rd_idx_q == '0) begin
          state_d          = S_GAP;
          gap_d            = '0;
          full_d[r_bank_q] = 1'b0;
          r_bank_d         = ~r_bank_q;
          frame_sent_d     = 1'b1;
          frames_d         = frames_q + 8'd1;
        end else begin
          in_valid_d = 1'b1;
          din_r_d    = rd_word[DW-1:IN_WIDTH];
          din_i_d    = rd_word[IN_WIDTH-1:0];
          rd_idx_d   = rd_idx_q + AW'(1);
        end
      end
      S_GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) state_d = S_IDLE;
        else                              gap_d   = gap_q + GW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      full_q       <= '0;
      w_bank_q     <= 1'b0;
      r_bank_q     <= 1'b0;
      w_idx_q      <= '0;
      rd_idx_q     <= '0;
      gap_q        <= '0;
      frames_q     <= '0;
      in_valid_q   <= 1'b0;
      din_r_q      <= '0;
      din_i_q      <= '0;
      frame_sent_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      full_q       <= full_d;
      w_bank_q     <= w_bank_d;
      r_bank_q     <= r_bank_d;
      w_idx_q      <= w_idx_d;
      rd_idx_q     <= rd_idx_d;
      gap_q        <= gap_d;
      frames_q     <= frames_d;
      in_valid_q   <= in_valid_d;
      din_r_q      <= din_r_d;
      din_i_q      <= din_i_d;
      frame_sent_q <= frame_sent_d;
    end
  end

  assign in_valid    = in_valid_q;
  assign din_r       = din_r_q;
  assign din_i       = din_i_q;
  assign frame_sent  = frame_sent_q;
  assign frames_sent = frames_q;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Directed bench for fft_frame_feeder: frame order, hold-off, backpressure,
// streaming spacing, mid-burst reset and paused fills.
module tb_fft_frame_feeder;
  localparam int N = 32;
  localparam int W = 12;

  logic         clk = 1'b0;
  logic         reset, s_valid, s_ready, fft_idle, in_valid, frame_sent;
  logic [W-1:0] s_data_r, s_data_i, din_r, din_i;
  logic [7:0]   frames_sent;

  fft_frame_feeder #(.FFT_SIZE(N), .IN_WIDTH(W), .GAP_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .s_data_r(s_data_r), .s_data_i(s_data_i), .fft_idle(fft_idle),
    .in_valid(in_valid), .din_r(din_r), .din_i(din_i),
    .frame_sent(frame_sent), .frames_sent(frames_sent));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Observer: appends only; tests work from snapshot bases.
  logic [2*W-1:0] rx_q[$];
  int blen_q[$];
  int gap_q[$];
  int nz_err = 0, fs_bad = 0, fs_cnt = 0, cyc = 0, cur_len = 0, last_end = 0;
  bit prev_iv = 0, seen_burst = 0;

  always @(posedge clk) begin
    #1;
    if (reset) begin
      prev_iv = 0; seen_burst = 0; cur_len = 0;
    end else begin
      if (in_valid) begin
        if (!prev_iv && seen_burst) gap_q.push_back(cyc - last_end);
        rx_q.push_back({din_r, din_i});
        cur_len++;
      end else if (din_r != '0 || din_i != '0) nz_err++;
      if (prev_iv && !in_valid) begin
        blen_q.push_back(cur_len); cur_len = 0; last_end = cyc; seen_burst = 1;
      end
      if (frame_sent) begin
        fs_cnt++;
        if (!(prev_iv && !in_valid)) fs_bad++;
      end else if (prev_iv && !in_valid) fs_bad++;
      prev_iv = in_valid;
    end
    cyc++;
  end

  logic [2*W-1:0] exp_q[$];
  int rx_base, bl_base, gap_base, nz_base, fsb_base, fsc_base;

  task automatic clr();
    rx_base = rx_q.size(); bl_base = blen_q.size(); gap_base = gap_q.size();
    nz_base = nz_err; fsb_base = fs_bad; fsc_base = fs_cnt;
    exp_q.delete();
  endtask

  task automatic push(input int r, input int im);
    int t;
    t = 0;
    s_valid = 1'b1; s_data_r = W'(r); s_data_i = W'(im);
    while (!s_ready && t < 500) begin @(negedge clk); t++; end
    if (!s_ready) begin
      checks++; errors++;
      $display("FAIL push_timeout: s_ready=%0b required 1", s_ready);
    end else exp_q.push_back({W'(r), W'(im)});
    @(posedge clk); @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_bursts(input int n, output bit ok);
    int t;
    t = 0;
    while (blen_q.size() - bl_base < n && t < 3000) begin @(negedge clk); t++; end
    @(negedge clk);
    ok = (blen_q.size() - bl_base >= n);
  endtask

  task automatic test_reset();
    checks += 5;
    if (in_valid !== 1'b0) begin errors++; $display("FAIL rst_in_valid: got %0b want 0", in_valid); end
    if (din_r !== '0 || din_i !== '0) begin errors++; $display("FAIL rst_din: got %0h/%0h want 0", din_r, din_i); end
    if (frame_sent !== 1'b0) begin errors++; $display("FAIL rst_frame_sent: got %0b want 0", frame_sent); end
    if (frames_sent !== 8'd0) begin errors++; $display("FAIL rst_frames_sent: got %0d want 0", frames_sent); end
    if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_s_ready: got %0b want 1", s_ready); end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1 || in_valid !== 1'b0) begin
      errors++; $display("FAIL post_rst: s_ready=%0b in_valid=%0b want 1/0", s_ready, in_valid);
    end
  endtask

  task automatic test_basic();
    bit ok;
    clr(); fft_idle = 1'b1;
    for (int k = 0; k < N; k++) push(k, -k);
    checks++;
    if (in_valid !== 1'b0) begin errors++; $display("FAIL basic_early: in_valid=%0b want 0", in_valid); end
    @(negedge clk);
    checks++;
    if (in_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: in_valid=%0b want 1", in_valid); end
    wait_bursts(1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout: bursts=%0d want 1", blen_q.size() - bl_base); end
    checks++;
    if (rx_q.size() - rx_base !== N) begin errors++; $display("FAIL basic_len: got %0d want %0d", rx_q.size() - rx_base, N); end
    for (int i = 0; i < N && rx_base + i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[rx_base + i] !== exp_q[i]) begin errors++; $display("FAIL basic_data[%0d]: got %h want %h", i, rx_q[rx_base + i], exp_q[i]); end
    end
    checks += 4;
    if (frames_sent !== 8'd1) begin errors++; $display("FAIL basic_frames: got %0d want 1", frames_sent); end
    if (fs_cnt - fsc_base !== 1) begin errors++; $display("FAIL basic_fs_count: got %0d want 1", fs_cnt - fsc_base); end
    if (fs_bad - fsb_base !== 0) begin errors++; $display("FAIL basic_fs_timing: got %0d bad want 0", fs_bad - fsb_base); end
    if (nz_err - nz_base !== 0) begin errors++; $display("FAIL basic_din_idle: got %0d nonzero want 0", nz_err - nz_base); end
  endtask

  task automatic test_hold();
    bit ok;
    int bad;
    clr(); fft_idle = 1'b0; bad = 0;
    for (int k = 0; k < N; k++) push(100 + k, -(100 + k));
    repeat (10) begin @(negedge clk); if (in_valid || !s_ready) bad++; end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL hold_blocked: got %0d bad cycles want 0", bad); end
    fft_idle = 1'b1;
    checks++;
    if (in_valid !== 1'b0) begin errors++; $display("FAIL hold_early: in_valid=%0b want 0", in_valid); end
    @(negedge clk);
    checks++;
    if (in_valid !== 1'b1) begin errors++; $display("FAIL hold_start: in_valid=%0b want 1", in_valid); end
    wait_bursts(1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL hold_timeout: bursts=%0d want 1", blen_q.size() - bl_base); end
    for (int i = 0; i < N && rx_base + i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[rx_base + i] !== exp_q[i]) begin errors++; $display("FAIL hold_data[%0d]: got %h want %h", i, rx_q[rx_base + i], exp_q[i]); end
    end
    checks++;
    if (frames_sent !== 8'd2) begin errors++; $display("FAIL hold_frames: got %0d want 2", frames_sent); end
  endtask

  task automatic test_both_full();
    bit ok, saw;
    int bad, bad2;
    clr(); fft_idle = 1'b0; bad = 0; bad2 = 0; saw = 0;
    for (int k = 0; k < 2 * N; k++) push(200 + k, k - 500);
    checks++;
    if (s_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %0b want 0", s_ready); end
    s_valid = 1'b1; s_data_r = 12'h7ff; s_data_i = 12'h7ff;
    repeat (5) begin @(negedge clk); if (s_ready) bad++; end
    s_valid = 1'b0;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL full_65th: got %0d ready cycles want 0", bad); end
    fft_idle = 1'b1;
    for (int t = 0; t < 200 && !saw; t++) begin
      @(negedge clk);
      if (in_valid && s_ready) bad2++;
      if (frame_sent) begin
        saw = 1;
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL full_ready_return: got %0b want 1", s_ready); end
      end
    end
    checks += 2;
    if (!saw) begin errors++; $display("FAIL full_no_frame_sent: got 0 want 1"); end
    if (bad2 !== 0) begin errors++; $display("FAIL full_ready_in_burst: got %0d want 0", bad2); end
    wait_bursts(2, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL full_timeout: bursts=%0d want 2", blen_q.size() - bl_base); end
    checks += 2;
    if (rx_q.size() - rx_base !== 2 * N) begin errors++; $display("FAIL full_len: got %0d want %0d", rx_q.size() - rx_base, 2 * N); end
    if (gap_q.size() == 0 || gap_q[gap_q.size() - 1] !== 2) begin
      errors++; $display("FAIL full_gap: got %0d want 2", (gap_q.size() == 0) ? -1 : gap_q[gap_q.size() - 1]);
    end
    for (int i = 0; i < 2 * N && rx_base + i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[rx_base + i] !== exp_q[i]) begin errors++; $display("FAIL full_data[%0d]: got %h want %h", i, rx_q[rx_base + i], exp_q[i]); end
    end
    checks++;
    if (frames_sent !== 8'd4) begin errors++; $display("FAIL full_frames: got %0d want 4", frames_sent); end
  endtask

  task automatic test_stream5();
    bit ok;
    reset = 1'b1; @(negedge clk); reset = 1'b0; @(negedge clk);
    clr(); fft_idle = 1'b1;
    for (int k = 0; k < 5 * N; k++) push(k[0] ? -2047 : 2047, k[1] ? 2047 - k : -2047 + k);
    wait_bursts(5, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stream_timeout: bursts=%0d want 5", blen_q.size() - bl_base); end
    for (int b = 0; b < 5 && bl_base + b < blen_q.size(); b++) begin
      checks++;
      if (blen_q[bl_base + b] !== N) begin errors++; $display("FAIL stream_blen[%0d]: got %0d want %0d", b, blen_q[bl_base + b], N); end
    end
    checks++;
    if (gap_q.size() - gap_base !== 4) begin errors++; $display("FAIL stream_gap_count: got %0d want 4", gap_q.size() - gap_base); end
    for (int g = gap_base; g < gap_q.size(); g++) begin
      checks++;
      if (gap_q[g] !== 2) begin errors++; $display("FAIL stream_gap[%0d]: got %0d want 2", g - gap_base, gap_q[g]); end
    end
    for (int i = 0; i < 5 * N && rx_base + i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[rx_base + i] !== exp_q[i]) begin errors++; $display("FAIL stream_data[%0d]: got %h want %h", i, rx_q[rx_base + i], exp_q[i]); end
    end
    checks += 2;
    if (frames_sent !== 8'd5) begin errors++; $display("FAIL stream_frames: got %0d want 5", frames_sent); end
    if (nz_err - nz_base !== 0) begin errors++; $display("FAIL stream_din_idle: got %0d want 0", nz_err - nz_base); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int t;
    clr(); fft_idle = 1'b1; t = 0;
    for (int k = 0; k < N + 5; k++) push(600 + k, k);
    while (rx_q.size() - rx_base < 10 && t < 200) begin @(negedge clk); t++; end
    checks++;
    if (rx_q.size() - rx_base < 10) begin errors++; $display("FAIL midrst_no_burst: got %0d samples want 10", rx_q.size() - rx_base); end
    reset = 1'b1;
    #1;
    checks += 4;
    if (in_valid !== 1'b0) begin errors++; $display("FAIL midrst_in_valid: got %0b want 0", in_valid); end
    if (din_r !== '0 || din_i !== '0) begin errors++; $display("FAIL midrst_din: got %0h/%0h want 0", din_r, din_i); end
    if (frames_sent !== 8'd0) begin errors++; $display("FAIL midrst_frames: got %0d want 0", frames_sent); end
    if (s_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %0b want 1", s_ready); end
    @(negedge clk); reset = 1'b0; @(negedge clk);
    clr();
    for (int k = 0; k < N; k++) push(-50 * (k + 1), 60 * k);
    wait_bursts(1, ok);
    checks += 3;
    if (!ok) begin errors++; $display("FAIL midrst_timeout: bursts=%0d want 1", blen_q.size() - bl_base); end
    if (rx_q.size() - rx_base !== N) begin errors++; $display("FAIL midrst_len: got %0d want %0d", rx_q.size() - rx_base, N); end
    if (frames_sent !== 8'd1) begin errors++; $display("FAIL midrst_frames_after: got %0d want 1", frames_sent); end
    for (int i = 0; i < N && rx_base + i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[rx_base + i] !== exp_q[i]) begin errors++; $display("FAIL midrst_data[%0d]: got %h want %h", i, rx_q[rx_base + i], exp_q[i]); end
    end
  endtask

  task automatic test_partial();
    bit ok;
    int bad;
    clr(); bad = 0;
    for (int k = 0; k < 20; k++) push(1000 + k, -(1000 + k));
    repeat (100) begin @(negedge clk); if (in_valid) bad++; end
    checks += 2;
    if (bad !== 0) begin errors++; $display("FAIL partial_early_burst: got %0d cycles want 0", bad); end
    if (s_ready !== 1'b1) begin errors++; $display("FAIL partial_ready: got %0b want 1", s_ready); end
    for (int k = 20; k < N; k++) push(1000 + k, -(1000 + k));
    wait_bursts(1, ok);
    checks += 3;
    if (!ok) begin errors++; $display("FAIL partial_timeout: bursts=%0d want 1", blen_q.size() - bl_base); end
    if (rx_q.size() - rx_base !== N) begin errors++; $display("FAIL partial_len: got %0d want %0d", rx_q.size() - rx_base, N); end
    if (frames_sent !== 8'd2) begin errors++; $display("FAIL partial_frames: got %0d want 2", frames_sent); end
    for (int i = 0; i < N && rx_base + i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[rx_base + i] !== exp_q[i]) begin errors++; $display("FAIL partial_data[%0d]: got %h want %h", i, rx_q[rx_base + i], exp_q[i]); end
    end
  endtask

  initial begin
    reset = 1'b1; s_valid = 1'b0; s_data_r = '0; s_data_i = '0; fft_idle = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_hold();
    test_both_full();
    test_stream5();
    test_reset_mid();
    test_partial();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
